// File: rtl/fifo_rd_burst_pkg.sv
// Shared state encoding and default widths for the FIFO read-side burst sequencer.
package fifo_rd_burst_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 8;
    localparam int TO_W_DEF   = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OPEN  = 2'd1;
    localparam logic [1:0] ST_CLOSE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_OPEN  = ST_OPEN,
        S_CLOSE = ST_CLOSE
    } state_e;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit saturating event counter; only built when FIFO_BURST_STATS_EN is defined.
`ifdef FIFO_BURST_STATS_EN
module sat_cnt16 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc,
    output logic [15:0] cnt
);
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= 16'd0;
        else         cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule
`endif

// File: rtl/fifo_rd_burst_ctrl.sv
// Read sequencer for axis_async_fifo: pulls words, holds one back so tlast lands on the real
// final beat of a length- or timeout-closed burst. FIFO_BURST_STATS_EN adds burst/timeout counters.
module fifo_rd_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int TO_W   = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic [LEN_W-1:0]  cfg_burst_len,
    input  logic [TO_W-1:0]   cfg_timeout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic [15:0]       stat_bursts,
    output logic [15:0]       stat_timeouts
);
    import fifo_rd_burst_pkg::*;

    state_e             state_q, state_d;
    logic               hold_vld_q, hold_vld_d;
    logic               hold_last_q, hold_last_d;
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;

    logic               out_free, rd_fire, hold_mv, beat_is_last, timeout_hit, close_req;
    logic [LEN_W-1:0]   len_m1;

    assign len_m1       = (cfg_burst_len == '0) ? '0 : cfg_burst_len - LEN_W'(1);
    assign out_free     = !tvalid_q || m_axis_tready;
    // A read is only allowed when the held word can leave in the same cycle.
    assign rd_fire      = resetn && en && !fifo_empty && (!hold_vld_q || (out_free && !hold_last_q));
    assign hold_mv      = hold_vld_q && out_free && (hold_last_q || rd_fire);
    assign beat_is_last = (beat_cnt_q == len_m1);
    assign timeout_hit  = (state_q == S_OPEN) && !rd_fire && (cfg_timeout != '0) &&
                          ((idle_cnt_q + TO_W'(1)) == cfg_timeout);
    assign close_req    = (state_q == S_OPEN) && !rd_fire && (timeout_hit || !en);

    always_comb begin
        state_d     = state_q;
        hold_vld_d  = hold_vld_q;
        hold_last_d = hold_last_q;
        hold_data_d = hold_data_q;
        beat_cnt_d  = beat_cnt_q;
        idle_cnt_d  = '0;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;

        if (rd_fire) begin
            hold_vld_d  = 1'b1;
            hold_data_d = fifo_rd_data;
            hold_last_d = beat_is_last;
            beat_cnt_d  = beat_is_last ? '0 : beat_cnt_q + LEN_W'(1);
        end else if (hold_mv) begin
            hold_vld_d  = 1'b0;
            hold_last_d = 1'b0;
        end else if (close_req) begin
            hold_last_d = 1'b1;
            beat_cnt_d  = '0;
        end

        if ((state_q == S_OPEN) && !rd_fire) idle_cnt_d = idle_cnt_q + TO_W'(1);

        case (state_q)
            S_IDLE:  if (rd_fire) state_d = beat_is_last ? S_CLOSE : S_OPEN;
            S_OPEN: begin
                if (rd_fire)        state_d = beat_is_last ? S_CLOSE : S_OPEN;
                else if (close_req) state_d = S_CLOSE;
            end
            S_CLOSE: if (hold_mv) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (hold_mv) begin
            tvalid_d = 1'b1;
            tdata_d  = hold_data_q;
            tlast_d  = hold_last_q;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            hold_vld_q  <= 1'b0;
            hold_last_q <= 1'b0;
            hold_data_q <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            beat_cnt_q  <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_vld_q  <= hold_vld_d;
            hold_last_q <= hold_last_d;
            hold_data_q <= hold_data_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            beat_cnt_q  <= beat_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign fifo_rd_en    = rd_fire;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = hold_vld_q || tvalid_q;

`ifdef FIFO_BURST_STATS_EN
    sat_cnt16 u_stat_bursts (
        .clk    (clk),
        .resetn (resetn),
        .inc    (tvalid_q && m_axis_tready && tlast_q),
        .cnt    (stat_bursts)
    );
    sat_cnt16 u_stat_timeouts (
        .clk    (clk),
        .resetn (resetn),
        .inc    (timeout_hit),
        .cnt    (stat_timeouts)
    );
`else
    assign stat_bursts   = 16'd0;
    assign stat_timeouts = 16'd0;
`endif

endmodule

// File: doc/fifo_rd_burst_ctrl.md
Name: fifo_rd_burst_ctrl

Overview:
Read-side sequencer for axis_async_fifo, clocked in the FIFO's rd_clk domain. Drives the FIFO rd_en from fifo_empty and downstream backpressure. Packs the words it reads into AXI-stream bursts with tlast, closing a burst either at a programmed length or after an idle timeout. Holds one word back so that tlast can be attached to the true final beat.

Parameters:
DATA_W, 16, FIFO word width (matches FIFO rd_data)
LEN_W, 8, width of burst-length config and beat counter
TO_W, 8, width of timeout config and idle counter

Ports:
clk  in  1  clock; the FIFO's rd_clk
resetn  in  1  asynchronous active-low reset
en  in  1  controller enable; 0 = stop reading, flush held word
cfg_burst_len  in  LEN_W  beats per burst; 0 treated as 1
cfg_timeout  in  TO_W  idle cycles before a partial burst closes; 0 = timeout disabled
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read strobe
fifo_rd_data  in  DATA_W  FIFO read data, valid combinationally in the cycle fifo_rd_en=1
m_axis_tdata  out  DATA_W  output data
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last beat of burst
busy  out  1  hold or output register occupied
stat_bursts  out  16  bursts completed (BURST_STATS_EN)
stat_timeouts  out  16  bursts closed by timeout (BURST_STATS_EN)

Behaviour:
- Storage is two registers. Hold register: hold_vld, hold_data, hold_last. Output register: tvalid, tdata, tlast. out_free = !tvalid || tready.
- Hold moves to output (hold_mv) when hold_vld && out_free && (hold_last || rd_fire).
- fifo_rd_en = en && !fifo_empty && (!hold_vld || hold_mv_possible), where hold_mv_possible = out_free && !hold_last. It is purely combinational; rd_fire = fifo_rd_en.
- On rd_fire: fifo_rd_data is captured into hold, and beat_cnt increments. If beat_cnt == max(cfg_burst_len,1)-1, hold_last=1 and beat_cnt wraps to 0.
- Output register: loads hold on hold_mv (tvalid=1, tlast=hold_last). Otherwise clears tvalid when tready=1.
- While tvalid=1 && tready=0: tdata and tlast are stable.
- FSM on the hold register:
  - IDLE: hold empty. Goes to OPEN on rd_fire of a non-last beat, or to CLOSE on rd_fire of a last beat.
  - OPEN: hold holds a non-last beat.
    - idle_cnt increments each cycle without rd_fire and clears on rd_fire.
    - When idle_cnt reaches cfg_timeout (cfg_timeout != 0), or when en=0: hold_last=1, beat_cnt=0, go to CLOSE.
    - A rd_fire in OPEN keeps OPEN, or goes to CLOSE if the new beat is last.
  - CLOSE: hold_last=1 and no reads occur. Goes to IDLE on hold_mv.
- Latency: a word reaches m_axis one cycle after the read that captured it, at the earliest. A non-last word waits for the next read or the close.
- Simultaneous timeout expiry and rd_fire in the same cycle: rd_fire wins and idle_cnt clears.
- cfg_burst_len is sampled per beat. Changing it mid-burst takes effect at the next compare.
- en=0 mid-burst: no further reads; the held word leaves with tlast=1 and the output drains normally.
- busy = hold_vld || tvalid.
- Reset (asynchronous, any time): state=IDLE, hold_vld=0, tvalid=0, tlast=0, tdata=0, beat_cnt=0, idle_cnt=0, stats=0. fifo_rd_en is 0 while resetn=0.

Optional Feature:
FIFO_BURST_STATS_EN
- Defined:
  - stat_bursts increments on each accepted beat with tlast=1 (tvalid && tready && tlast).
  - stat_timeouts increments when OPEN goes to CLOSE due to timeout.
  - Both counters are 16-bit and saturate at 0xFFFF.
- Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Package fifo_rd_burst_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_OPEN=2'd1, ST_CLOSE=2'd2
  - default widths
- Optional sub-module sat_cnt16: saturating counter with increment enable, instanced twice under the macro.
- Otherwise a single module.

Test Plan:
- Length close: cfg_burst_len=4, cfg_timeout=0, FIFO holds 8 words 0x0001..0x0008, tready=1. Expect two bursts, with tlast on 0x0004 and 0x0008. fifo_rd_en is never high while fifo_empty=1.
- Timeout close: cfg_burst_len=8, cfg_timeout=5, 3 words written then none. Expect 0x0001 and 0x0002 output without tlast. 0x0003 appears with tlast=1 exactly 6 cycles after its read. stat_timeouts=1.
- Backpressure: cfg_burst_len=4, tready held 0 for 10 cycles. Expect at most 2 words read (output plus hold), tdata/tlast stable throughout, and the full sequence intact after release.
- Length 0 and wrap: cfg_burst_len=0 gives tlast on every beat. cfg_burst_len=255 over 510 words gives tlast on beats 255 and 510, confirming beat_cnt wrap.
- Disable mid-burst: en falls after 2 of 4 beats. Expect the second word to emerge with tlast=1, no further fifo_rd_en, then busy=0.
- Async reset with tvalid=1 and hold full: tvalid, tlast, busy and fifo_rd_en go to 0 immediately without a clock edge. After release the next burst starts with beat_cnt=0.
